// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding,
// default timeout, MEM/WB register layout and an alignment helper.
package mem_access_stage_pkg;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  dest;
  } mem_wb_t;

  // Word accesses only: any nonzero low address bit is a fault.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_dmem_bus_fsm.sv
// Data-memory bus handshake: issues one registered request per aligned
// memory op, waits for ack or timeout, and stalls the pipeline meanwhile.
module dmem_bus_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ack,
  output logic        req,
  output logic        we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  mem_state_e    state;
  logic [CW-1:0] count;
  logic          start;

  // Decode the current cycle: launch, completion, abandonment and stall.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    start   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    stall   = 1'b0;
    if (state == MEM_IDLE) begin
      start = (mem_read || mem_write) && !is_misaligned(addr);
      stall = start;
    end else begin
      done    = ack;
      timeout = !ack && (count == LAST);
      stall   = !ack && (count != LAST);
    end
  end

  // State, timeout counter and registered bus outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!reset) begin
      state     <= MEM_IDLE;
      count     <= '0;
      req       <= 1'b0;
      we        <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (state == MEM_IDLE) begin
      if (start) begin
        state     <= MEM_ACCESS;
        count     <= '0;
        req       <= 1'b1;
        we        <= mem_write;
        req_addr  <= addr;
        req_wdata <= wdata;
      end
    end else begin
      if (done || timeout) begin
        state <= MEM_IDLE;
        req   <= 1'b0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory handshake through
// dmem_bus_fsm, holds the MEM/WB register, squashes register writes of
// faulting instructions and keeps sticky fault flags.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] data_in,
  input  logic [4:0]  Dest_Reg_Addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  Dest_Reg_Addr_out,
  output logic        misalign_err,
  output logic        bus_err
);

  logic    done;
  logic    timeout;
  logic    mem_op;
  logic    is_load;
  logic    idle_pass;
  logic    misalign_hit;
  mem_wb_t mem_wb;
  mem_wb_t mem_wb_next;

  dmem_bus_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_bus (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (MemRead_in),
    .mem_write (MemWrite_in),
    .addr      (ALU_result_in),
    .wdata     (data_in),
    .ack       (dmem_ack),
    .req       (dmem_req),
    .we        (dmem_we),
    .req_addr  (dmem_addr),
    .req_wdata (dmem_wdata),
    .stall     (stall),
    .done      (done),
    .timeout   (timeout)
  );

  // Next MEM/WB contents: bubble while stalled, otherwise the instruction
  // with its register write squashed if it faulted.
  always_comb begin
    mem_op       = MemRead_in || MemWrite_in;
    is_load      = MemRead_in && !MemWrite_in;
    idle_pass    = !stall && !done && !timeout;
    misalign_hit = idle_pass && mem_op && is_misaligned(ALU_result_in);
    mem_wb_next  = mem_wb;
    if (stall) begin
      mem_wb_next.reg_write  = 1'b0;
      mem_wb_next.mem_to_reg = 1'b0;
    end else begin
      mem_wb_next.reg_write  = RegWrite_in && !timeout && !misalign_hit;
      mem_wb_next.mem_to_reg = MemtoReg_in;
      mem_wb_next.alu_result = ALU_result_in;
      mem_wb_next.dest       = Dest_Reg_Addr_in;
      if (done && is_load) begin
        mem_wb_next.read_data = dmem_rdata;
      end
    end
  end

  // MEM/WB register and sticky fault flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_wb       <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      mem_wb <= mem_wb_next;
      if (misalign_hit) misalign_err <= 1'b1;
      if (timeout)      bus_err      <= 1'b1;
    end
  end

  assign RegWrite_out      = mem_wb.reg_write;
  assign MemtoReg_out      = mem_wb.mem_to_reg;
  assign read_data_out     = mem_wb.read_data;
  assign ALU_result_out    = mem_wb.alu_result;
  assign Dest_Reg_Addr_out = mem_wb.dest;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a transaction-level model
// predicts stall length, bus activity and MEM/WB contents for each
// instruction; a negedge process compares the DUT against it every cycle.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
  logic [31:0] ALU_result_in, data_in;
  logic [4:0]  Dest_Reg_Addr_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] read_data_out, ALU_result_out;
  logic [4:0]  Dest_Reg_Addr_out;
  logic        misalign_err, bus_err;

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT(T)) dut (
    .clock             (clock),
    .reset             (reset),
    .RegWrite_in       (RegWrite_in),
    .MemtoReg_in       (MemtoReg_in),
    .MemRead_in        (MemRead_in),
    .MemWrite_in       (MemWrite_in),
    .ALU_result_in     (ALU_result_in),
    .data_in           (data_in),
    .Dest_Reg_Addr_in  (Dest_Reg_Addr_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .stall             (stall),
    .RegWrite_out      (RegWrite_out),
    .MemtoReg_out      (MemtoReg_out),
    .read_data_out     (read_data_out),
    .ALU_result_out    (ALU_result_out),
    .Dest_Reg_Addr_out (Dest_Reg_Addr_out),
    .misalign_err      (misalign_err),
    .bus_err           (bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle.
  logic        m_stall, m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_rw, m_mtr;
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_dest;
  logic        m_mis, m_bus;
  bit          chk_en = 1'b0;
  int          stall_seen = 0;
  int          req_seen = 0;

  task automatic model_clear();
    m_stall = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    m_rw = 0; m_mtr = 0; m_rdata = 0; m_alu = 0; m_dest = 0;
    m_mis = 0; m_bus = 0;
  endtask

  // Compare DUT against model every cycle, midway between edges.
  always @(negedge clock) begin
    if (chk_en) begin
      check("stall",        32'(stall),        32'(m_stall));
      check("dmem_req",     32'(dmem_req),     32'(m_req));
      if (m_req) begin
        check("dmem_we",    32'(dmem_we),      32'(m_we));
        check("dmem_addr",  dmem_addr,         m_addr);
        check("dmem_wdata", dmem_wdata,        m_wdata);
      end
      check("RegWrite_out", 32'(RegWrite_out), 32'(m_rw));
      check("MemtoReg_out", 32'(MemtoReg_out), 32'(m_mtr));
      check("read_data",    read_data_out,     m_rdata);
      check("alu_result",   ALU_result_out,    m_alu);
      check("dest",         32'(Dest_Reg_Addr_out), 32'(m_dest));
      check("misalign_err", 32'(misalign_err), 32'(m_mis));
      check("bus_err",      32'(bus_err),      32'(m_bus));
      if (stall)    stall_seen++;
      if (dmem_req) req_seen++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction. ack_delay = ACCESS cycles before ack
  // (0 = first ACCESS cycle); negative or >= T means no ack in time.
  // idle_ack drives dmem_ack during non-ACCESS cycles (must be ignored).
  task automatic do_instr(input logic rw, input logic mtr, input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                          input int ack_delay, input logic [31:0] rd, input logic idle_ack);
    bit mem, mis, acked;
    int last;
    RegWrite_in = rw; MemtoReg_in = mtr; MemRead_in = mr; MemWrite_in = mw;
    ALU_result_in = alu; data_in = wd; Dest_Reg_Addr_in = dest;
    dmem_ack = idle_ack; dmem_rdata = $urandom;
    mem = mr | mw;
    mis = (alu & 32'h3) != 0;
    stall_seen = 0;
    req_seen = 0;
    if (!mem || mis) begin
      m_stall = 0;
      tick();
      m_alu = alu; m_dest = dest; m_mtr = mtr;
      m_rw = rw & !(mem & mis);
      if (mem) m_mis = 1;
    end else begin
      m_stall = 1;
      tick();
      m_rw = 0; m_mtr = 0;
      m_req = 1; m_we = mw; m_addr = alu; m_wdata = wd;
      acked = (ack_delay >= 0) && (ack_delay < T);
      last = acked ? ack_delay : T - 1;
      for (int c = 0; c <= last; c++) begin
        dmem_ack = acked && (c == ack_delay);
        dmem_rdata = dmem_ack ? rd : $urandom;
        m_stall = (c < last);
        tick();
        if (c < last) begin m_rw = 0; m_mtr = 0; end
      end
      m_req = 0;
      m_alu = alu; m_dest = dest; m_mtr = mtr;
      m_rw = rw & acked;
      if (acked && mr && !mw) m_rdata = rd;
      if (!acked) m_bus = 1;
      dmem_ack = 0;
    end
  endtask

  initial begin
    reset = 0;
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    ALU_result_in = 0; data_in = 0; Dest_Reg_Addr_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    check("rst_req",   32'(dmem_req),      0);
    check("rst_stall", 32'(stall),         0);
    check("rst_rw",    32'(RegWrite_out),  0);
    check("rst_rdata", read_data_out,      0);
    check("rst_alu",   ALU_result_out,     0);
    check("rst_mis",   32'(misalign_err),  0);
    check("rst_bus",   32'(bus_err),       0);
    chk_en = 1;

    // Add op passes straight through in one cycle.
    do_instr(1, 0, 0, 0, 32'h1234, 0, 5'd5, 0, 0, 0);
    check("add_rw",    32'(RegWrite_out), 1);
    check("add_alu",   ALU_result_out, 32'h1234);
    check("add_dest",  32'(Dest_Reg_Addr_out), 5);
    check("add_stall", stall_seen, 0);

    // Load 0x100, ack 3 cycles after request rises.
    do_instr(1, 1, 1, 0, 32'h100, 0, 5'd7, 3, 32'hDEADBEEF, 0);
    check("ld_stall_cycles", stall_seen, 4);
    check("ld_req_cycles",   req_seen, 4);
    check("ld_rdata",        read_data_out, 32'hDEADBEEF);
    check("ld_mtr",          32'(MemtoReg_out), 1);

    // Store, ack in first ACCESS cycle.
    do_instr(0, 0, 0, 1, 32'h200, 32'hCAFEF00D, 5'd0, 0, 0, 0);
    check("st_stall_cycles", stall_seen, 1);
    check("st_req_cycles",   req_seen, 1);
    check("st_rw",           32'(RegWrite_out), 0);
    check("st_rdata_hold",   read_data_out, 32'hDEADBEEF);

    // Misaligned load.
    do_instr(1, 1, 1, 0, 32'h103, 0, 5'd9, 0, 0, 0);
    check("mis_stall", stall_seen, 0);
    check("mis_req",   req_seen, 0);
    check("mis_flag",  32'(misalign_err), 1);
    check("mis_rw",    32'(RegWrite_out), 0);

    // Load that never gets acked, then late acks in IDLE.
    do_instr(1, 1, 1, 0, 32'h400, 0, 5'd3, -1, 0, 0);
    check("to_req_cycles", req_seen, T);
    check("to_bus",        32'(bus_err), 1);
    check("to_rw",         32'(RegWrite_out), 0);
    do_instr(0, 0, 0, 0, 32'h0, 0, 5'd0, 0, 0, 1);
    do_instr(0, 0, 0, 0, 32'h0, 0, 5'd0, 0, 0, 1);
    check("late_ack_req", 32'(dmem_req), 0);

    // Randomized instruction mix.
    for (int i = 0; i < 300; i++) begin
      int kind, d;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      d = $urandom_range(0, 5);
      if (d == 5) d = -1;
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (kind == 1 || kind == 3), (kind == 2 || kind == 3),
               a, $urandom, 5'($urandom_range(0, 31)), d, $urandom,
               1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-ACCESS.
    chk_en = 0;
    RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; MemWrite_in = 0;
    ALU_result_in = 32'h300; Dest_Reg_Addr_in = 5'd4; dmem_ack = 0;
    tick();
    check("mid_req", 32'(dmem_req), 1);
    reset = 0;
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    ALU_result_in = 0; Dest_Reg_Addr_in = 0;
    tick();
    check("rst2_req",   32'(dmem_req),     0);
    check("rst2_stall", 32'(stall),        0);
    check("rst2_rw",    32'(RegWrite_out), 0);
    check("rst2_alu",   ALU_result_out,    0);
    check("rst2_rdata", read_data_out,     0);
    check("rst2_mis",   32'(misalign_err), 0);
    check("rst2_bus",   32'(bus_err),      0);
    reset = 1;
    model_clear();
    chk_en = 1;
    do_instr(1, 1, 1, 0, 32'h500, 0, 5'd6, 1, 32'h55AA, 0);
    check("post_rst_rdata", read_data_out, 32'h55AA);
    check("post_rst_stall", stall_seen, 2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
